// File: rtl/seq_mul_add_pkg.sv
// ============================================================================
// Module  : seq_mul_add_pkg
// Purpose : Shared constants and FSM state encoding for the sequential
//           multiply-accumulate block (product = M*Q + C).
// Contents: WIDTH, ITERS, CNT_W, ADD_OP, state_e
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package seq_mul_add_pkg;

  localparam int WIDTH = 8;               // operand width, product is 2*WIDTH
  localparam int ITERS = 8;               // one shift-add iteration per multiplier bit
  localparam int CNT_W = 3;               // iteration counter width
  localparam logic ADD_OP = 1'b1;         // adder opcode selecting addition

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL    = 3'd1,
    S_ADD_LO = 3'd2,
    S_ADD_HI = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_mul_add_if.sv
// ============================================================================
// Module  : seq_mul_add_if
// Purpose : Operand/result handshake bundle for seq_mul_add.
// Ports   : master drives operands and out_ready;
//           slave (the block) drives in_ready, out_valid and product.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_mul_add_if;
  import seq_mul_add_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     addend;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, multiplicand, multiplier, addend, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, addend, out_ready,
    output in_ready, out_valid, product
  );

endinterface

`default_nettype wire

// File: rtl/seq_mul_add_addsub.sv
// ============================================================================
// Module  : parallel_adder_subtractor
// Purpose : 8-bit ripple-style adder/subtractor.
//           op_i=1 : {sign_out_o, result_o} = x_i + y_i + sign_in_i
//           op_i=0 : {sign_out_o, result_o} = x_i + ~y_i + 1 (x - y, carry = no borrow)
// Ports   : x_i, y_i (8) operands; op_i opcode; sign_in_i carry in on add;
//           result_o (8) sum; sign_out_o carry out
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module parallel_adder_subtractor (
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  input  logic       op_i,
  input  logic       sign_in_i,
  output logic [7:0] result_o,
  output logic       sign_out_o
);

  logic [7:0] y_eff;
  logic       cin;

  assign y_eff = op_i ? y_i : ~y_i;
  assign cin   = op_i ? sign_in_i : 1'b1;
  assign {sign_out_o, result_o} = {1'b0, x_i} + {1'b0, y_eff} + {8'b0, cin};

endmodule

`default_nettype wire

// File: rtl/seq_mul_add.sv
// ============================================================================
// Module  : seq_mul_add
// Purpose : Sequential unsigned multiply-accumulate, product = M*Q + C.
//           Eight shift-add iterations, then the addend is folded into the
//           low and high product bytes, all through one shared adder.
// Ports   : clk, rst (sync, active-high)
//           bus (slave): in_valid/in_ready + multiplicand/multiplier/addend,
//                        out_valid/out_ready + product[15:0]
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module seq_mul_add
  import seq_mul_add_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  seq_mul_add_if.slave  bus
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     c_q, c_d;
  logic                 carry_q, carry_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 out_valid_q, out_valid_d;

  logic [WIDTH-1:0]     add_x, add_y, add_res;
  logic                 add_co;
  logic [WIDTH:0]       sum;

  parallel_adder_subtractor u_addsub (
    .x_i        (add_x),
    .y_i        (add_y),
    .op_i       (ADD_OP),
    .sign_in_i  (1'b0),
    .result_o   (add_res),
    .sign_out_o (add_co)
  );

  assign sum          = {add_co, add_res};
  assign bus.in_ready = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    c_d         = c_q;
    carry_d     = carry_q;
    count_d     = count_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    add_x       = '0;
    add_y       = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          m_d     = bus.multiplicand;
          q_d     = bus.multiplier;
          c_d     = bus.addend;
          a_d     = '0;
          carry_d = 1'b0;
          count_d = '0;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        // Add M when the current multiplier bit is set, then shift the
        // 17-bit {carry, A, Q} right by one; Q fills with product bits.
        add_x   = a_q;
        add_y   = q_q[0] ? m_q : '0;
        a_d     = sum[WIDTH:1];
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(ITERS - 1)) begin
          state_d = S_ADD_LO;
        end
      end

      S_ADD_LO: begin
        add_x   = q_q;
        add_y   = c_q;
        q_d     = add_res;
        carry_d = add_co;
        state_d = S_ADD_HI;
      end

      S_ADD_HI: begin
        // M*Q + C <= 0xFF00, so this carry propagation never overflows.
        add_x       = a_q;
        add_y       = {{(WIDTH-1){1'b0}}, carry_q};
        a_d         = add_res;
        product_d   = {add_res, q_q};
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      c_q         <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      c_q         <= c_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_mul_add.sv
// ============================================================================
// Module  : tb_seq_mul_add
// Purpose : Self-checking bench for seq_mul_add against an arithmetic
//           reference (M*Q + C) and a divide/reconstruct round trip.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_mul_add;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_mul_add_if bus ();

  seq_mul_add dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [7:0] m, input logic [7:0] q, input logic [7:0] c);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 30) check_eq("in_ready_timeout", 32'd0, 32'd1);
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.addend       = c;
    bus.in_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid     = 1'b0;
    bus.multiplicand = 8'($urandom);
    bus.multiplier   = 8'($urandom);
    bus.addend       = 8'($urandom);
  endtask

  // Counts rising edges from the accept edge until out_valid is seen.
  task automatic wait_result(output logic [15:0] prod, output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    prod = bus.product;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] q,
                        input logic [7:0] c, input bit chk_lat);
    logic [15:0] prod;
    int          lat;
    int          expv;
    expv = int'(m) * int'(q) + int'(c);
    start_op(m, q, c);
    wait_result(prod, lat);
    if (chk_lat) check_eq({tag, "_latency"}, lat, 32'd10);
    check_eq(tag, {16'd0, prod}, expv);
    consume();
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] prod, p0;
    int          lat;
    bit          ok;

    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.addend       = '0;
    bus.out_ready    = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", bus.out_valid, 32'd0);
    check_eq("rst_product", bus.product, 32'd0);
    check_eq("rst_in_ready", bus.in_ready, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", bus.in_ready, 32'd1);

    // Directed values and boundaries
    run_op("m13_q11_c7", 8'd13, 8'd11, 8'd7, 1'b1);
    run_op("max_all", 8'd255, 8'd255, 8'd255, 1'b1);
    run_op("addhi_carry", 8'd1, 8'd1, 8'd255, 1'b1);
    run_op("zero_m", 8'd0, 8'd200, 8'd0, 1'b1);

    // Output hold with a competing request waiting
    start_op(8'd50, 8'd60, 8'd70);
    wait_result(p0, lat);
    check_eq("hold_first_latency", lat, 32'd10);
    check_eq("hold_first_product", {16'd0, p0}, 32'd3070);
    bus.multiplicand = 8'd9;
    bus.multiplier   = 8'd9;
    bus.addend       = 8'd9;
    bus.in_valid     = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.product !== p0 || bus.in_ready !== 1'b0) ok = 1'b0;
    end
    check_eq("hold_stable", {31'd0, ok}, 32'd1);
    check_eq("hold_product", bus.product, 32'd3070);
    check_eq("hold_in_ready", bus.in_ready, 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("release_out_valid", bus.out_valid, 32'd0);
    check_eq("release_in_ready", bus.in_ready, 32'd1);
    start_op(8'd9, 8'd9, 8'd9);
    wait_result(prod, lat);
    check_eq("queued_latency", lat, 32'd10);
    check_eq("queued_product", {16'd0, prod}, 32'd90);
    consume();

    // Reset in the middle of the multiply
    start_op(8'd200, 8'd100, 8'd50);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_out_valid", bus.out_valid, 32'd0);
    check_eq("midrst_in_ready", bus.in_ready, 32'd0);
    check_eq("midrst_product", bus.product, 32'd0);
    rst = 1'b0;
    ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) ok = 1'b0;
    end
    check_eq("midrst_no_pulse", {31'd0, ok}, 32'd1);
    run_op("after_rst", 8'd6, 8'd7, 8'd0, 1'b1);

    // Random operands with C < M, with random output stalls
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] m, q, c;
      int         stall;
      int         expv;
      m = 8'($urandom_range(255, 1));
      q = 8'($urandom_range(255, 0));
      c = 8'($urandom_range(int'(m) - 1, 0));
      expv = int'(m) * int'(q) + int'(c);
      start_op(m, q, c);
      wait_result(prod, lat);
      check_eq("rand_product", {16'd0, prod}, expv);
      stall = $urandom_range(2, 0);
      repeat (stall) @(negedge clk);
      if (stall != 0) check_eq("rand_stall_hold", bus.product, expv);
      consume();
    end

    // Divide a dividend, then rebuild it from quotient and remainder
    for (int i = 0; i < 50; i++) begin
      int v, d, qd, rd;
      v  = $urandom_range(255, 1);
      d  = $urandom_range(255, 0) * v + $urandom_range(v - 1, 0);
      qd = d / v;
      rd = d % v;
      start_op(8'(v), 8'(qd), 8'(rd));
      wait_result(prod, lat);
      check_eq("roundtrip", {16'd0, prod}, d);
      consume();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
